uart_xmt: RTL



---
 rtl/uart_xmt_if.sv | 9 +
 rtl/uart_xmt.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_xmt_if.sv
// Character handshake between a producer and the UART transmitter.
interface uart_xmt_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_xmt.sv
// UART transmitter: start, 5-8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Bit period is (sample_width+1)*SAMPLE_BITS clocks, matching the receiver.
//
// state  | meaning
// IDLE   | line high, ready for a character
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit
// STOP   | one or two stop bits (high)
module uart_xmt #(
   parameter int SAMPLE_WIDTH_BITS = 15,
   parameter int SAMPLE_BITS       = 5
) (
   input  logic                         clk,
   input  logic                         nRst,
   input  logic [SAMPLE_WIDTH_BITS-1:0] sample_width,
   input  logic                         en_parity,
   input  logic                         odd_parity,
   input  logic [1:0]                   data_bits,
   input  logic                         stop_bits,
   uart_xmt_if.slave                    in_bus,
   output logic                         busy,
   output logic                         tx_done,
   output logic                         TXD
);

   localparam int TW = (SAMPLE_BITS > 1) ? $clog2(SAMPLE_BITS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                       state, state_nxt;
   logic [7:0]                   shreg;
   logic [2:0]                   last_idx;
   logic [2:0]                   bit_idx;
   logic                         par_bit;
   logic                         en_par;
   logic                         stop_two;
   logic [SAMPLE_WIDTH_BITS-1:0] sw_lat;
   logic [SAMPLE_WIDTH_BITS-1:0] presc;
   logic [TW-1:0]                tick_cnt;
   logic                         txd_nxt;
   logic                         done_nxt;
   logic                         accept;
   logic                         tick;
   logic                         bit_end;
   logic [7:0]                   data_mask;
   logic [2:0]                   last_in;

   always_comb begin
      last_in   = 3'd7;
      data_mask = 8'hFF;
      case (data_bits)
         2'd1: begin last_in = 3'd4; data_mask = 8'h1F; end
         2'd2: begin last_in = 3'd5; data_mask = 8'h3F; end
         2'd3: begin last_in = 3'd6; data_mask = 8'h7F; end
         default: ;
      endcase
   end

   assign in_bus.in_ready = (state == IDLE);
   assign busy            = (state != IDLE);
   assign accept          = in_bus.in_valid && (state == IDLE);
   assign tick            = (presc == sw_lat);
   assign bit_end         = tick && (tick_cnt == TICK_LAST);

   always_ff @(posedge clk) begin
      if (!nRst) begin
         state   <= IDLE;
         TXD     <= 1'b1;
         tx_done <= 1'b0;
      end else begin
         state   <= state_nxt;
         TXD     <= txd_nxt;
         tx_done <= done_nxt;
      end
   end

   // TXD is registered, so the value for the next bit is chosen here.
   always_comb begin
      state_nxt = state;
      txd_nxt   = TXD;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            txd_nxt = 1'b1;
            if (accept) begin
               state_nxt = START;
               txd_nxt   = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_nxt = DATA;
               txd_nxt   = shreg[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx != last_idx) begin
                  txd_nxt = shreg[1];
               end else if (en_par) begin
                  state_nxt = PARITY;
                  txd_nxt   = par_bit;
               end else begin
                  state_nxt = STOP;
                  txd_nxt   = 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_nxt = STOP;
               txd_nxt   = 1'b1;
            end
         end
         STOP: begin
            txd_nxt = 1'b1;
            if (bit_end && !(stop_two && bit_idx == 3'd0)) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            txd_nxt   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nRst) begin
         shreg    <= '0;
         last_idx <= '0;
         bit_idx  <= '0;
         par_bit  <= 1'b0;
         en_par   <= 1'b0;
         stop_two <= 1'b0;
         sw_lat   <= '0;
         presc    <= '0;
         tick_cnt <= '0;
      end else if (accept) begin
         shreg    <= in_bus.in_data & data_mask;
         last_idx <= last_in;
         bit_idx  <= '0;
         par_bit  <= odd_parity ^ (^(in_bus.in_data & data_mask));
         en_par   <= en_parity;
         stop_two <= stop_bits;
         sw_lat   <= sample_width;
         presc    <= '0;
         tick_cnt <= '0;
      end else if (state != IDLE) begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick) tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
         if (bit_end) begin
            if (state == DATA) shreg <= shreg >> 1;
            bit_idx <= (state_nxt == state) ? bit_idx + 3'd1 : 3'd0;
         end
      end
   end

endmodule
